// File: rtl/qe_pulse_generator_pkg.sv
// qe_pulse_generator_pkg
// Shared types and constants for the quadrature pulse generator.
//   qe_dir_t              : step direction (QE_CW / QE_CCW), taken from the command sign bit
//   qe_gen_state_t        : generator control states (IDLE / RUN)
//   QE_GEN_MIN_PHASE_TIME : smallest usable clocks-per-edge value
//   qe_phase_to_ab        : quadrature phase -> {A,B} output mapping
package qe_pulse_generator_pkg;

  typedef enum logic {
    QE_CW  = 1'b0,
    QE_CCW = 1'b1
  } qe_dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } qe_gen_state_t;

  localparam int QE_GEN_MIN_PHASE_TIME = 1;

  // Gray-coded sequence so CW steps raise A before B.
  function automatic logic [1:0] qe_phase_to_ab(input logic [1:0] phase);
    logic [1:0] ab;
    case (phase)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/qe_phase_timer.sv
// qe_phase_timer
// Load/decrement down-counter that paces quadrature edges.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   load       : load count with load_value (wins over dec)
//   load_value : value to load
//   dec        : decrement count by one (saturates at zero)
//   zero       : count is zero
module qe_phase_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/qe_pulse_generator.sv
// qe_pulse_generator
// Converts a signed step command into A/B/I quadrature edges, one edge every
// phase_time clocks. Commands arrive over a valid/ready handshake.
// Optional feature macro: QE_GEN_INDEX_EN (index output from a revolution
// counter; when undefined QE_I is tied low and counts_per_rev is ignored).
//   clk             : system clock
//   reset           : asynchronous active-low reset
//   cmd_valid/ready : command handshake (ready only while idle)
//   cmd_steps       : signed step count, positive = CW, negative = CCW
//   cmd_phase_time  : clocks per edge, 0 behaves as 1
//   counts_per_rev  : edges per revolution, 0 disables the index
//   abort           : stop the running command without a done pulse
//   QE_A/QE_B/QE_I  : quadrature outputs
//   busy            : command in progress
//   done            : one-cycle pulse on command completion
//   steps_remaining : edges still to emit
//   position        : signed accumulated edge count
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | emitting edges, one per phase_time clocks
module qe_pulse_generator
  import qe_pulse_generator_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COUNT_WIDTH-1:0] cmd_steps,
  input  logic [COUNT_WIDTH-1:0] cmd_phase_time,
  input  logic [COUNT_WIDTH-1:0] counts_per_rev,
  input  logic                   abort,
  output logic                   QE_A,
  output logic                   QE_B,
  output logic                   QE_I,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] steps_remaining,
  output logic [COUNT_WIDTH-1:0] position
);

  localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] MIN_PT = COUNT_WIDTH'(QE_GEN_MIN_PHASE_TIME);

  qe_gen_state_t          state, state_next;
  qe_dir_t                dir;
  logic [1:0]             phase;
  logic [COUNT_WIDTH-1:0] phase_time;
  logic [COUNT_WIDTH-1:0] cmd_mag, cmd_pt_eff, timer_load_value;
  logic                   accept, emit, abort_run, done_next;
  logic                   timer_load, timer_dec, timer_zero;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state == RUN);
  assign accept     = cmd_valid && cmd_ready;
  // Two's-complement negate; the most negative value maps to 2^(W-1) unsigned.
  assign cmd_mag    = cmd_steps[COUNT_WIDTH-1] ? (~cmd_steps + ONE) : cmd_steps;
  assign cmd_pt_eff = (cmd_phase_time < MIN_PT) ? MIN_PT : cmd_phase_time;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next       = state;
    emit             = 1'b0;
    abort_run        = 1'b0;
    done_next        = 1'b0;
    timer_load       = 1'b0;
    timer_dec        = 1'b0;
    timer_load_value = cmd_pt_eff - ONE;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_steps != '0) begin
            state_next = RUN;
            timer_load = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort wins over an edge that would land in the same cycle.
        if (abort) begin
          abort_run  = 1'b1;
          state_next = IDLE;
        end else if (timer_zero) begin
          emit             = 1'b1;
          timer_load       = 1'b1;
          timer_load_value = phase_time - ONE;
          if (steps_remaining == ONE) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  qe_phase_timer #(.WIDTH(COUNT_WIDTH)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir             <= QE_CW;
      phase           <= 2'd0;
      phase_time      <= MIN_PT;
      steps_remaining <= '0;
      position        <= '0;
      done            <= 1'b0;
    end else begin
      done <= done_next;
      if (accept) begin
        dir             <= qe_dir_t'(cmd_steps[COUNT_WIDTH-1]);
        steps_remaining <= cmd_mag;
        phase_time      <= cmd_pt_eff;
      end else if (abort_run) begin
        steps_remaining <= '0;
      end else if (emit) begin
        steps_remaining <= steps_remaining - ONE;
        if (dir == QE_CW) begin
          phase    <= phase + 2'd1;
          position <= position + ONE;
        end else begin
          phase    <= phase - 2'd1;
          position <= position - ONE;
        end
      end
    end
  end

  assign {QE_A, QE_B} = qe_phase_to_ab(phase);

`ifdef QE_GEN_INDEX_EN
  logic [COUNT_WIDTH-1:0] cpr, rev_count;

  // rev_count persists across commands; with cpr == 0 it simply holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpr       <= '0;
      rev_count <= '0;
    end else begin
      if (accept) cpr <= counts_per_rev;
      if (emit && (cpr != '0)) begin
        if (dir == QE_CW) begin
          rev_count <= (rev_count >= cpr - ONE) ? '0 : rev_count + ONE;
        end else begin
          rev_count <= ((rev_count == '0) || (rev_count >= cpr)) ? cpr - ONE
                                                                 : rev_count - ONE;
        end
      end
    end
  end

  assign QE_I = (rev_count == '0) && (cpr != '0);
`else
  logic unused_cpr;
  assign unused_cpr = ^counts_per_rev;
  assign QE_I       = 1'b0;
`endif

endmodule

// File: tb/tb_qe_pulse_generator.sv
module tb_qe_pulse_generator;

`ifdef QE_GEN_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid, cmd_ready, abort;
  logic [31:0] cmd_steps, cmd_phase_time, counts_per_rev;
  logic        QE_A, QE_B, QE_I, busy, done;
  logic [31:0] steps_remaining, position;

  qe_pulse_generator #(.COUNT_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_steps       (cmd_steps),
    .cmd_phase_time  (cmd_phase_time),
    .counts_per_rev  (counts_per_rev),
    .abort           (abort),
    .QE_A            (QE_A),
    .QE_B            (QE_B),
    .QE_I            (QE_I),
    .busy            (busy),
    .done            (done),
    .steps_remaining (steps_remaining),
    .position        (position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  ab;
    logic        i;
    logic [31:0] pos;
    logic [31:0] rem;
  } edge_t;

  typedef struct {
    int          cyc;
    logic [31:0] pos;
  } done_t;

  edge_t       eq[$];
  done_t       dq[$];
  logic [31:0] m_pos;
  int          m_rev;
  int          last_final;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Quadrature output expected for a given accumulated position.
  function automatic logic [1:0] ab_of(input logic [31:0] p);
    case (p[1:0])
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // mode 0: run to completion, 1: abort after stop_after edges, 2: reset after stop_after edges
  task automatic issue(input logic [31:0] steps, input logic [31:0] pt, input logic [31:0] cpr,
                       input int mode, input int stop_after, output int base);
    logic [31:0] mag, ept;
    logic        rdy, got;
    int          n, c;
    edge_t       e;
    done_t       d;
    mag = steps[31] ? (32'd0 - steps) : steps;
    ept = (pt == 32'd0) ? 32'd1 : pt;
    c   = int'(cpr);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = steps; cmd_phase_time = pt; counts_per_rev = cpr;
    got = 1'b0;
    for (int t = 0; t < 2000 && !got; t++) begin
      rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) got = 1'b1;
      else @(negedge clk);
    end
    cmd_valid = 1'b0;
    base = cyc;
    check("accept_seen", {63'd0, got}, 64'd1);
    if (!got) return;
    check("accept_busy",  {63'd0, busy},      {63'd0, mag != 32'd0});
    check("accept_ready", {63'd0, cmd_ready}, {63'd0, mag == 32'd0});
    check("accept_rem",   {32'd0, steps_remaining}, {32'd0, mag});
    check("accept_idx",   {63'd0, QE_I}, {63'd0, IDX_EN && c != 0 && m_rev == 0});
    n = (mode == 0) ? int'(mag) : stop_after;
    for (int k = 1; k <= n; k++) begin
      if (steps[31]) begin
        m_pos = m_pos - 32'd1;
        if (c != 0) m_rev = (m_rev + c - 1) % c;
      end else begin
        m_pos = m_pos + 32'd1;
        if (c != 0) m_rev = (m_rev + 1) % c;
      end
      e.cyc = base + k * int'(ept);
      e.ab  = ab_of(m_pos);
      e.i   = IDX_EN && c != 0 && m_rev == 0;
      e.pos = m_pos;
      e.rem = mag - 32'(k);
      eq.push_back(e);
    end
    if (mode == 0) begin
      last_final = (mag == 32'd0) ? base : base + n * int'(ept);
      d.cyc = last_final;
      d.pos = m_pos;
      dq.push_back(d);
    end else begin
      repeat (n * int'(ept)) @(posedge clk);
      @(negedge clk);
      if (mode == 1) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_rem",   {32'd0, steps_remaining}, 64'd0);
        check("abort_ready", {63'd0, cmd_ready}, 64'd1);
        check("abort_busy",  {63'd0, busy}, 64'd0);
        check("abort_pos",   {32'd0, position}, {32'd0, m_pos});
        check("abort_done",  {63'd0, done}, 64'd0);
        repeat (int'(ept) + 2) @(negedge clk);
      end else begin
        #1 reset = 1'b0;
        #1;
        check("mrst_ab",    {62'd0, QE_A, QE_B}, 64'd0);
        check("mrst_i",     {63'd0, QE_I}, 64'd0);
        check("mrst_pos",   {32'd0, position}, 64'd0);
        check("mrst_rem",   {32'd0, steps_remaining}, 64'd0);
        check("mrst_ready", {63'd0, cmd_ready}, 64'd1);
        check("mrst_busy",  {63'd0, busy}, 64'd0);
        m_pos = 32'd0;
        m_rev = 0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((eq.size() != 0 || dq.size() != 0 || !cmd_ready) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 64'(eq.size() + dq.size()), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: every change on A/B and every done pulse consumes one expectation.
  initial begin
    logic [1:0] prev_ab, ab;
    edge_t      e;
    done_t      d;
    prev_ab = 2'b00;
    forever begin
      @(negedge clk);
      ab = {QE_A, QE_B};
      if (!reset) begin
        prev_ab = ab;
      end else begin
        if (ab != prev_ab) begin
          if (eq.size() == 0) begin
            check("unexpected_edge", {62'd0, ab}, {62'd0, prev_ab});
          end else begin
            e = eq.pop_front();
            check("edge_cyc", 64'(cyc), 64'(e.cyc));
            check("edge_ab",  {62'd0, ab}, {62'd0, e.ab});
            check("edge_pos", {32'd0, position}, {32'd0, e.pos});
            check("edge_rem", {32'd0, steps_remaining}, {32'd0, e.rem});
            check("edge_idx", {63'd0, QE_I}, {63'd0, e.i});
          end
        end else if (eq.size() != 0 && eq[0].cyc <= cyc) begin
          e = eq.pop_front();
          check("missed_edge", {62'd0, ab}, {62'd0, e.ab});
        end
        if (done) begin
          if (dq.size() == 0) begin
            check("unexpected_done", {63'd0, done}, 64'd0);
          end else begin
            d = dq.pop_front();
            check("done_cyc",   64'(cyc), 64'(d.cyc));
            check("done_pos",   {32'd0, position}, {32'd0, d.pos});
            check("done_busy",  {63'd0, busy}, 64'd0);
            check("done_ready", {63'd0, cmd_ready}, 64'd1);
          end
        end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
          d = dq.pop_front();
          check("missed_done", {63'd0, done}, 64'd1);
        end
        prev_ab = ab;
      end
    end
  end

  initial begin
    int          b, b2, f, s, mag, mode, stop;
    logic [31:0] pt, cpr;
    cmd_valid = 1'b0; cmd_steps = '0; cmd_phase_time = '0; counts_per_rev = '0; abort = 1'b0;
    m_pos = 32'd0; m_rev = 0; last_final = 0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_ab",    {62'd0, QE_A, QE_B}, 64'd0);
    check("rst_i",     {63'd0, QE_I}, 64'd0);
    check("rst_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_rem",   {32'd0, steps_remaining}, 64'd0);
    check("rst_pos",   {32'd0, position}, 64'd0);

    issue(32'd8, 32'd4, 32'd0, 0, 0, b);          wait_drain();
    issue(-32'sd3, 32'd1, 32'd0, 0, 0, b);        wait_drain();
    issue(32'd9, 32'd2, 32'd4, 0, 0, b);          wait_drain();
    issue(32'd10, 32'd3, 32'd0, 1, 5, b);         wait_drain();
    issue(32'd0, 32'd2, 32'd0, 0, 0, b);          wait_drain();
    issue(32'd4, 32'd0, 32'd0, 0, 0, b);          wait_drain();
    // second command held valid while the first is still running
    issue(32'd4, 32'd2, 32'd0, 0, 0, b);
    f = last_final;
    issue(-32'sd5, 32'd1, 32'd4, 0, 0, b2);
    check("held_accept_cyc", 64'(b2), 64'(f + 1));
    wait_drain();
    issue(32'h8000_0000, 32'd1, 32'd0, 1, 2, b);  wait_drain();
    issue(32'd6, 32'd2, 32'd4, 2, 3, b);          wait_drain();

    for (int it = 0; it < 24; it++) begin
      s    = int'($urandom_range(0, 24)) - 12;
      pt   = 32'($urandom_range(0, 4));
      cpr  = $urandom_range(0, 1) ? 32'd4 : 32'd0;
      mag  = (s < 0) ? -s : s;
      mode = (mag >= 2 && $urandom_range(0, 5) == 0) ? 1 : 0;
      stop = (mode == 1) ? int'($urandom_range(1, mag - 1)) : 0;
      issue(32'(s), pt, cpr, mode, stop, b);
      if (mode == 1 || $urandom_range(0, 1) == 1) wait_drain();
    end
    wait_drain();
    check("end_edges_left", 64'(eq.size()), 64'd0);
    check("end_pos", {32'd0, position}, {32'd0, m_pos});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
